// File: rtl/mem_wb_writer_pkg.sv
// Shared definitions for the memory-access / write-back stage: op codes,
// data and address sizes, FSM states and small op-decoding helpers.
package mem_wb_writer_pkg;

    localparam int DATA_SIZE      = 32;
    localparam int DATA_ADDR_SIZE = 32;
    localparam int REG_ADDR_SIZE  = 5;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Codes above SW are unused and behave like MEM_NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Number of byte transfers an op needs.
    function automatic logic [2:0] op_bytes(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 3'd1;
            LH, LHU, SH: return 3'd2;
            LW, SW:      return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_writer_load_extend.sv
// Turns the assembled little-endian load word into the register value:
// sign- or zero-extension for byte/half loads, passthrough for words.
module mem_wb_writer_load_extend
    import mem_wb_writer_pkg::*;
#(
    parameter int XLEN = DATA_SIZE
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] ext_o
);

    // Select the extension rule from the load op.
    always_comb begin
        ext_o = word_i;
        case (op_i)
            LB:      ext_o = {{(XLEN-8){word_i[7]}},   word_i[7:0]};
            LH:      ext_o = {{(XLEN-16){word_i[15]}}, word_i[15:0]};
            LBU:     ext_o = {{(XLEN-8){1'b0}},        word_i[7:0]};
            LHU:     ext_o = {{(XLEN-16){1'b0}},       word_i[15:0]};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_writer.sv
// Memory-access / write-back stage. Non-memory instructions write back one
// cycle after acceptance; loads and stores run byte-serially over the memory
// handshake while stalling the pipeline, loads then write back from WB.
module mem_wb_writer
    import mem_wb_writer_pkg::*;
#(
    parameter int ADDR_W = DATA_ADDR_SIZE,
    parameter int REG_AW = REG_ADDR_SIZE,
    parameter int XLEN   = DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic              ex_wb_flag,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_store_data,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              stall_req,
    output logic              wb_flag,
    output logic [REG_AW-1:0] wb_address,
    output logic [XLEN-1:0]   wb_data
);

    localparam int NBYTES = XLEN / 8;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [XLEN-1:0]   ldata_q, ldata_d;
    logic [2:0]        k_q, k_d;
    logic              wb_flag_q, wb_flag_d;
    logic [REG_AW-1:0] wb_address_q, wb_address_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              in_access;
    logic              accept_mem;
    logic              last_byte;
    logic [XLEN-1:0]   asm_word;
    logic [XLEN-1:0]   ext_word;
    logic [7:0]        store_byte;

    assign in_access = (state_q == ACCESS);
    assign last_byte = ((k_q + 3'd1) == op_bytes(op_q));

    // Load word as it will look once the byte arriving this cycle lands in lane k.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        assign asm_word[8*gi +: 8] = (k_q == 3'(gi)) ? mem_rdata : ldata_q[8*gi +: 8];
    end

    // Store byte k of the latched store data (little-endian).
    always_comb begin
        store_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k_q == 3'(i)) begin
                store_byte = sdata_q[8*i +: 8];
            end
        end
    end

    mem_wb_writer_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .op_i   (op_q),
        .word_i (asm_word),
        .ext_o  (ext_word)
    );

    // Next-state logic: accept, byte sequencing and write-back generation.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        base_d       = base_q;
        sdata_d      = sdata_q;
        ldata_d      = ldata_q;
        k_d          = k_q;
        wb_flag_d    = 1'b0;
        wb_address_d = wb_address_q;
        wb_data_d    = wb_data_q;
        accept_mem   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem_op(ex_mem_op)) begin
                        accept_mem = 1'b1;
                        op_d       = ex_mem_op;
                        rd_d       = ex_rd;
                        base_d     = ex_result[ADDR_W-1:0];
                        sdata_d    = ex_store_data;
                        ldata_d    = '0;
                        k_d        = 3'd0;
                        state_d    = ACCESS;
                    end else begin
                        // x0 is never written: the register file relies on this guard.
                        wb_flag_d    = ex_wb_flag && (ex_rd != '0);
                        wb_address_d = ex_rd;
                        wb_data_d    = ex_result;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    k_d = k_q + 3'd1;
                    if (is_load(op_q)) begin
                        ldata_d = asm_word;
                    end
                    if (last_byte) begin
                        if (is_load(op_q)) begin
                            state_d      = WB;
                            wb_flag_d    = (rd_q != '0);
                            wb_address_d = rd_q;
                            wb_data_d    = ext_word;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 4'd0;
            rd_q         <= '0;
            base_q       <= '0;
            sdata_q      <= '0;
            ldata_q      <= '0;
            k_q          <= 3'd0;
            wb_flag_q    <= 1'b0;
            wb_address_q <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            base_q       <= base_d;
            sdata_q      <= sdata_d;
            ldata_q      <= ldata_d;
            k_q          <= k_d;
            wb_flag_q    <= wb_flag_d;
            wb_address_q <= wb_address_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign mem_req    = in_access;
    assign mem_rw     = in_access && is_store(op_q);
    assign mem_addr   = in_access ? (base_q + ADDR_W'(k_q)) : '0;
    assign mem_wdata  = (in_access && is_store(op_q)) ? store_byte : 8'h00;
    assign stall_req  = in_access || accept_mem;
    assign wb_flag    = wb_flag_q;
    assign wb_address = wb_address_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_wb_writer.sv
// Randomized scoreboard bench for mem_wb_writer with a byte-wide memory
// responder and a reference model of the register write-back stream.
`timescale 1ns/1ps
module tb_mem_wb_writer;
    import mem_wb_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_mem_op = 4'd0;
    logic        ex_wb_flag = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_result = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic        mem_req, mem_rw, stall_req, wb_flag;
    logic [31:0] mem_addr, wb_data;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_ready = 1'b0;
    logic [4:0]  wb_address;

    always #5 clk = ~clk;

    mem_wb_writer dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
        .ex_wb_flag(ex_wb_flag), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall_req(stall_req), .wb_flag(wb_flag),
        .wb_address(wb_address), .wb_data(wb_data)
    );

    typedef struct { bit rw; logic [31:0] addr; logic [7:0] wdata; } acc_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    acc_t        exp_acc[$];
    wb_t         exp_wb[$];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  dut_mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_count = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    int          wb_cyc_by_rd [32];
    int          fixed_lat = -1;
    bit          spurious_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_default(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : mem_default(a);
    endfunction

    function automatic int nbytes(input int op);
        case (op)
            1, 4, 6: return 1;
            2, 5, 7: return 2;
            3, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    // Reference model: what the instruction should do to memory and the register file.
    task automatic model(input int op, input int rd, input bit wbf,
                         input logic [31:0] res, input logic [31:0] sd);
        int n;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] a;
        n = nbytes(op);
        if (n == 0) begin
            if (wbf && rd != 0) exp_wb.push_back('{rd: 5'(rd), data: res});
        end else if (op >= 6) begin
            for (int i = 0; i < n; i++) begin
                a = res + 32'(i);
                exp_acc.push_back('{rw: 1'b1, addr: a, wdata: sd[8*i +: 8]});
                ref_mem[a] = sd[8*i +: 8];
            end
        end else begin
            w = 32'd0;
            for (int i = 0; i < n; i++) begin
                a = res + 32'(i);
                exp_acc.push_back('{rw: 1'b0, addr: a, wdata: 8'h00});
                w = w + ({24'd0, ref_rd(a)} << (8 * i));
            end
            v = w;
            if (op == 1 && w >= 32'h80)   v = w + 32'hFFFF_FF00;
            if (op == 2 && w >= 32'h8000) v = w + 32'hFFFF_0000;
            if (rd != 0) exp_wb.push_back('{rd: 5'(rd), data: v});
        end
    endtask

    task automatic issue(input int op, input int rd, input bit wbf,
                         input logic [31:0] res, input logic [31:0] sd);
        bit is_mem;
        int guard;
        is_mem = (nbytes(op) != 0);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_op = 4'(op); ex_rd = 5'(rd);
        ex_wb_flag = wbf; ex_result = res; ex_store_data = sd;
        model(op, rd, wbf, res, sd);
        $display("issue op=%0d rd=%0d wbf=%0d res=0x%08h sd=0x%08h", op, rd, wbf, res, sd);
        #1 chk("stall_on_accept", {31'd0, stall_req}, {31'd0, is_mem});
        if (is_mem) begin
            @(posedge clk); #1;
            ex_valid = 1'b0;
            guard = 0;
            while (stall_req && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("access_timeout", {31'd0, guard < 200}, 32'd1);
            chk("req_dropped", {31'd0, mem_req}, 32'd0);
            if (op <= 5) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        dut_mem[a] = d;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: random latency, plus stray mem_ready while idle.
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                    if (mem_rw) dut_mem[mem_addr] = mem_wdata;
                    else        mem_rdata = dut_rd(mem_addr);
                    cnt = 0;
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (fixed_lat >= 0) lat = fixed_lat;
                if (spurious_en && $urandom_range(0, 3) == 0) mem_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expected accesses and write-backs as the DUT presents them.
    initial forever begin
        acc_t ea;
        wb_t  ew;
        @(negedge clk);
        if (!rst) begin
            if (mem_req) chk("stall_in_access", {31'd0, stall_req}, 32'd1);
            if (mem_req && mem_ready) begin
                hs_count++;
                last_hs_cyc = cyc;
                n_cmp++;
                if (exp_acc.size() == 0) begin
                    n_err++;
                    $display("FAIL acc_unexpected: got addr 0x%08h rw %0d expected no access", mem_addr, mem_rw);
                end else begin
                    ea = exp_acc.pop_front();
                    chk("acc_rw", {31'd0, mem_rw}, {31'd0, ea.rw});
                    chk("acc_addr", mem_addr, ea.addr);
                    if (ea.rw) chk("acc_wdata", {24'd0, mem_wdata}, {24'd0, ea.wdata});
                end
            end
            if (wb_flag) begin
                wb_cyc_by_rd[wb_address] = cyc;
                n_cmp++;
                if (exp_wb.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got rd %0d data 0x%08h expected no write-back", wb_address, wb_data);
                end else begin
                    ew = exp_wb.pop_front();
                    $display("wb rd=%0d data=0x%08h", wb_address, wb_data);
                    chk("wb_address", {27'd0, wb_address}, {27'd0, ew.rd});
                    chk("wb_data", wb_data, ew.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base_hs;
        int guard;
        int op;
        int rd;
        logic [31:0] a;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb_flag", {31'd0, wb_flag}, 32'd0);
        chk("rst_wb_address", {27'd0, wb_address}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;

        // ALU passthrough with explicit 1-cycle latency and single pulse.
        issue(0, 5, 1'b1, 32'h1234_5678, 32'd0);
        @(posedge clk); #1; ex_valid = 1'b0;
        @(negedge clk);
        chk("pt_latency_flag", {31'd0, wb_flag}, 32'd1);
        @(negedge clk);
        chk("pt_single_pulse", {31'd0, wb_flag}, 32'd0);

        // x0 guard.
        issue(0, 0, 1'b1, 32'hFFFF_FFFF, 32'd0);
        idle(3);

        // LH / LHU at a misaligned address, fixed latency 2.
        fixed_lat = 2;
        preload(32'h1001, 8'h80);
        preload(32'h1002, 8'hFF);
        issue(2, 3, 1'b1, 32'h1001, 32'd0);
        issue(5, 3, 1'b1, 32'h1001, 32'd0);
        fixed_lat = -1;

        // SW across the address wrap, then read it back.
        issue(8, 9, 1'b1, 32'hFFFF_FFFE, 32'hAABB_CCDD);
        issue(3, 10, 1'b1, 32'hFFFF_FFFE, 32'd0);
        idle(2);

        // Reset after the second byte of a LW.
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_op = 4'(3); ex_rd = 5'd7; ex_wb_flag = 1'b1;
        ex_result = 32'h2000; ex_store_data = 32'd0;
        $display("issue op=3 rd=7 res=0x00002000 (reset mid-access)");
        model(3, 7, 1'b1, 32'h2000, 32'd0);
        base_hs = hs_count;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        guard = 0;
        while (hs_count < base_hs + 2 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("lw_progress", {31'd0, guard < 200}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_stall", {31'd0, stall_req}, 32'd0);
        chk("abort_wb_flag", {31'd0, wb_flag}, 32'd0);
        rst = 1'b0;
        exp_acc.delete();
        exp_wb.delete();
        preload(32'h2100, 8'h9C);
        issue(1, 6, 1'b1, 32'h2100, 32'd0);

        // Back-to-back passthroughs, then LB.
        preload(32'h3000, 8'h7F);
        issue(0, 1, 1'b1, 32'h0000_0111, 32'd0);
        issue(0, 2, 1'b1, 32'h0000_0222, 32'd0);
        issue(1, 4, 1'b1, 32'h3000, 32'd0);
        chk("b2b_gap", 32'(wb_cyc_by_rd[2] - wb_cyc_by_rd[1]), 32'd1);
        chk("lb_wb_latency", 32'(wb_cyc_by_rd[4] - last_hs_cyc), 32'd1);

        // Random mix including unused op codes and addresses near the wrap.
        for (int t = 0; t < 150; t++) begin
            op = int'($urandom_range(0, 12));
            rd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h100 + 32'($urandom_range(0, 63));
            if (nbytes(op) == 0) a = $urandom;
            issue(op, rd, 1'($urandom), a, $urandom);
        end
        idle(6);

        chk("wb_queue_drained", exp_wb.size(), 32'd0);
        chk("acc_queue_drained", exp_acc.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
